// File: rtl/clk_div_pkg.sv
// Shared types and ratio arithmetic for the clock divider programmer.
package clk_div_pkg;

    localparam int DIV_W    = 8;
    localparam int SETTLE_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE,
        DONE
    } clk_div_prog_state_e;

    // A ratio of 0 means bypass, exactly like 1, so both collapse to 1.
    function automatic logic [DIV_W-1:0] div_norm(input logic [DIV_W-1:0] x);
        return (x == '0) ? DIV_W'(1) : x;
    endfunction

    // Folds a 9-bit intermediate back into the legal ratio range 1..255.
    function automatic logic [DIV_W-1:0] div_clamp(input logic [DIV_W:0] x);
        if (x == '0) begin
            return DIV_W'(1);
        end
        if (x[DIV_W]) begin
            return '1;
        end
        return x[DIV_W-1:0];
    endfunction

    // Next ratio on the way from cur to tgt. A step never passes the target,
    // so the last step may be shorter than max_step. max_step==0 jumps.
    function automatic logic [DIV_W-1:0] div_step(input logic [DIV_W-1:0] cur,
                                                  input logic [DIV_W-1:0] tgt,
                                                  input logic [DIV_W:0]   max_step);
        logic [DIV_W:0] c9;
        logic [DIV_W:0] t9;
        logic [DIV_W:0] diff;
        logic [DIV_W:0] res;
        c9   = {1'b0, cur};
        t9   = {1'b0, tgt};
        diff = (t9 >= c9) ? (t9 - c9) : (c9 - t9);
        if ((max_step == '0) || (diff <= max_step)) begin
            res = t9;
        end else if (t9 > c9) begin
            res = c9 + max_step;
        end else begin
            res = c9 - max_step;
        end
        return div_clamp(res);
    endfunction

endpackage

// File: rtl/clk_div_settle_timer.sv
// Down-counter that times the settle wait after each divider load.
module clk_div_settle_timer
    import clk_div_pkg::*;
#(
    parameter int WIDTH = SETTLE_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_count;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expire = (r_count == '0);

endmodule

// File: rtl/clock_divider_programmer.sv
// Ramps a clock divider to a requested ratio, one bounded step per load
// strobe, waiting a fixed plus ratio-dependent settle time after each step.
module clock_divider_programmer
    import clk_div_pkg::*;
#(
    parameter logic [7:0]  DIV_INIT      = 8'hFF,
    parameter int unsigned MAX_STEP      = 0,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DIV_W-1:0] req_div,
    output logic [DIV_W-1:0] clk_div,
    output logic             clk_div_valid,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy,
    output logic             done
);

    // Any step larger than 255 can never limit a ramp, so it is saturated to 256.
    localparam logic [DIV_W:0]      MaxStep9    = (MAX_STEP > 255) ? 9'd256 : MAX_STEP[DIV_W:0];
    localparam logic [SETTLE_W-1:0] SettleBase  = SETTLE_CYCLES[SETTLE_W-1:0];
    localparam logic [DIV_W-1:0]    DivInitNorm = div_norm(DIV_INIT);

    clk_div_prog_state_e r_state;
    clk_div_prog_state_e w_stateNext;
    logic [DIV_W-1:0]    r_clkDiv;
    logic [DIV_W-1:0]    r_curDiv;
    logic [DIV_W-1:0]    r_target;
    logic [DIV_W-1:0]    w_clkDivNext;
    logic [DIV_W-1:0]    w_curDivNext;
    logic [DIV_W-1:0]    w_targetNext;
    logic [DIV_W-1:0]    w_reqNorm;
    logic [DIV_W-1:0]    w_stepIdle;
    logic [DIV_W-1:0]    w_stepRamp;
    logic [SETTLE_W-1:0] w_settleLoad;
    logic                w_timerLoad;
    logic                w_timerExpire;

    assign w_reqNorm  = div_norm(req_div);
    assign w_stepIdle = div_step(r_curDiv, w_reqNorm, MaxStep9);
    assign w_stepRamp = div_step(r_curDiv, r_target, MaxStep9);

    // One cycle less than the full wait, because the counter also spends a cycle at zero.
    assign w_settleLoad = SettleBase + {1'b0, r_curDiv, 1'b0} - SETTLE_W'(1);

    clk_div_settle_timer #(
        .WIDTH(SETTLE_W)
    ) u_settleTimer (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_timerLoad),
        .i_loadValue(w_settleLoad),
        .o_expire   (w_timerExpire)
    );

    // Next-state and next-ratio decode; ratio registers only move on entry to ISSUE.
    always_comb begin
        w_stateNext  = r_state;
        w_clkDivNext = r_clkDiv;
        w_curDivNext = r_curDiv;
        w_targetNext = r_target;
        w_timerLoad  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_targetNext = w_reqNorm;
                    if (w_reqNorm == r_curDiv) begin
                        w_stateNext = DONE;
                    end else begin
                        w_clkDivNext = w_stepIdle;
                        w_curDivNext = w_stepIdle;
                        w_stateNext  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_timerLoad = 1'b1;
                w_stateNext = SETTLE;
            end
            SETTLE: begin
                if (w_timerExpire) begin
                    if (r_curDiv == r_target) begin
                        w_stateNext = DONE;
                    end else begin
                        w_clkDivNext = w_stepRamp;
                        w_curDivNext = w_stepRamp;
                        w_stateNext  = ISSUE;
                    end
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State, target and ratio registers; reset restores the divider's own reset ratio.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_clkDiv <= DIV_INIT;
            r_curDiv <= DivInitNorm;
            r_target <= DivInitNorm;
        end else begin
            r_state  <= w_stateNext;
            r_clkDiv <= w_clkDivNext;
            r_curDiv <= w_curDivNext;
            r_target <= w_targetNext;
        end
    end

    assign clk_div       = r_clkDiv;
    assign cur_div       = r_curDiv;
    assign clk_div_valid = (r_state == ISSUE);
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign req_ready     = (r_state == IDLE) && !rst;

endmodule

// File: tb/tb_clock_divider_programmer.sv
// Scoreboard bench for clock_divider_programmer: three instances with
// different step sizes; stimulus pushes expected pulses/done events and a
// negedge monitor pops and compares them against what each instance emits.
module tb_clock_divider_programmer;

    localparam int Settle = 8;

    logic       clk;
    logic       rst;
    logic       reqValid[3];
    logic [7:0] reqDiv[3];
    logic       reqReady[3];
    logic [7:0] clkDiv[3];
    logic       clkDivValid[3];
    logic [7:0] curDiv[3];
    logic       busyO[3];
    logic       doneO[3];

    typedef struct {
        int         dut;
        bit         isDone;
        logic [7:0] div;
        int         cycle;
    } exp_t;

    exp_t       expQ[$];
    exp_t       e;
    int         total;
    int         bad;
    int         cyc;
    logic [7:0] heldDiv[3];
    bit         readyChk[3];

    // dut0 jumps directly, dut1 ramps by 50, dut2 ramps by 2 and starts at 1.
    clock_divider_programmer #(.DIV_INIT(8'hFF), .MAX_STEP(0), .SETTLE_CYCLES(Settle)) dutA (
        .clk(clk), .rst(rst), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .req_div(reqDiv[0]), .clk_div(clkDiv[0]), .clk_div_valid(clkDivValid[0]),
        .cur_div(curDiv[0]), .busy(busyO[0]), .done(doneO[0]));

    clock_divider_programmer #(.DIV_INIT(8'hFF), .MAX_STEP(50), .SETTLE_CYCLES(Settle)) dutB (
        .clk(clk), .rst(rst), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .req_div(reqDiv[1]), .clk_div(clkDiv[1]), .clk_div_valid(clkDivValid[1]),
        .cur_div(curDiv[1]), .busy(busyO[1]), .done(doneO[1]));

    clock_divider_programmer #(.DIV_INIT(8'h01), .MAX_STEP(2), .SETTLE_CYCLES(Settle)) dutC (
        .clk(clk), .rst(rst), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
        .req_div(reqDiv[2]), .clk_div(clkDiv[2]), .clk_div_valid(clkDivValid[2]),
        .cur_div(curDiv[2]), .busy(busyO[2]), .done(doneO[2]));

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after the k-th rising edge cyc==k.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Offer a request, hold it until accepted, then queue the hand-computed
    // pulse ratios (steps, first in the low byte) and the final done event.
    task automatic applyStimulus(input int d, input logic [7:0] div, input int nSteps,
                                 input logic [47:0] steps, input logic [7:0] finalDiv);
        int   budget;
        int   acceptEdge;
        int   pc;
        exp_t x;
        @(negedge clk);
        #1;
        reqDiv[d]   = div;
        reqValid[d] = 1'b1;
        budget = 0;
        while (!reqReady[d] && budget < 5000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (budget >= 5000) begin
            total++;
            bad++;
            $display("[TB] FAIL accept timeout dut%0d: got ready=0 expected ready=1", d);
            reqValid[d] = 1'b0;
            return;
        end
        acceptEdge = cyc + 1;
        pc = acceptEdge + 1;
        for (int i = 0; i < nSteps; i++) begin
            x.dut = d; x.isDone = 1'b0; x.div = steps[8*i +: 8]; x.cycle = pc;
            expQ.push_back(x);
            pc = pc + 1 + Settle + 2 * int'(steps[8*i +: 8]);
        end
        x.dut = d; x.isDone = 1'b1; x.div = finalDiv; x.cycle = pc;
        expQ.push_back(x);
        @(posedge clk);
        #1;
        reqValid[d] = 1'b0;
    endtask

    // Wait (bounded) until every queued event has been seen, plus one cycle.
    task automatic waitDrain();
        int budget;
        budget = 0;
        while (expQ.size() != 0 && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain timeout: got %0d pending expected 0", expQ.size());
            expQ.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic checkResetValues();
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("dut%0d reset clk_div", d), clkDiv[d], (d == 2) ? 1 : 255);
            checkOutput($sformatf("dut%0d reset cur_div", d), curDiv[d], (d == 2) ? 1 : 255);
            checkOutput($sformatf("dut%0d reset req_ready", d), reqReady[d], 1);
            checkOutput($sformatf("dut%0d reset clk_div_valid", d), clkDivValid[d], 0);
            checkOutput($sformatf("dut%0d reset busy", d), busyO[d], 0);
            checkOutput($sformatf("dut%0d reset done", d), doneO[d], 0);
        end
    endtask

    // Monitor: pops the scoreboard on every pulse or done, checks clk_div is
    // stable outside pulses and that req_ready returns right after done.
    always @(negedge clk) begin
        if (rst) begin
            heldDiv[0] = 8'hFF;
            heldDiv[1] = 8'hFF;
            heldDiv[2] = 8'h01;
            for (int d = 0; d < 3; d++) readyChk[d] = 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (readyChk[d]) begin
                    readyChk[d] = 1'b0;
                    checkOutput($sformatf("dut%0d ready after done", d), reqReady[d], 1);
                end
                if (!clkDivValid[d]) begin
                    checkOutput($sformatf("dut%0d clk_div stable", d), clkDiv[d], heldDiv[d]);
                end
                if (clkDivValid[d] || doneO[d]) begin
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected event dut%0d: got valid=%0d done=%0d expected none",
                                 d, clkDivValid[d], doneO[d]);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("event dut", d, e.dut);
                        checkOutput($sformatf("dut%0d event is done", d), doneO[d], int'(e.isDone));
                        checkOutput($sformatf("dut%0d event cycle", d), cyc + 1, e.cycle);
                        checkOutput($sformatf("dut%0d event cur_div", d), curDiv[d], e.div);
                        checkOutput($sformatf("dut%0d event busy", d), busyO[d], 1);
                        if (clkDivValid[d]) begin
                            checkOutput($sformatf("dut%0d pulse clk_div", d), clkDiv[d], e.div);
                        end
                    end
                    if (clkDivValid[d]) heldDiv[d] = clkDiv[d];
                    if (doneO[d]) readyChk[d] = 1'b1;
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int d = 0; d < 3; d++) begin
            reqValid[d] = 1'b0;
            reqDiv[d]   = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset values");
        checkResetValues();

        $display("[TB] direct jump 255 -> 4");
        applyStimulus(0, 8'd4, 1, {40'd0, 8'd4}, 8'd4);
        waitDrain();

        $display("[TB] reset mid-settle");
        applyStimulus(0, 8'd200, 1, {40'd0, 8'd200}, 8'd200);
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b1;
        expQ.delete();
        @(posedge clk);
        @(negedge clk);
        checkOutput("in reset clk_div_valid", clkDivValid[0], 0);
        checkOutput("in reset clk_div", clkDiv[0], 255);
        checkOutput("in reset req_ready", reqReady[0], 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetValues();

        $display("[TB] bypass targets");
        applyStimulus(0, 8'd3, 1, {40'd0, 8'd3}, 8'd3);
        waitDrain();
        applyStimulus(0, 8'd0, 1, {40'd0, 8'd1}, 8'd1);
        waitDrain();
        applyStimulus(0, 8'd1, 0, 48'd0, 8'd1);
        waitDrain();
        checkOutput("bypass clk_div", clkDiv[0], 1);

        $display("[TB] ramp by 50 down to 100");
        applyStimulus(1, 8'd100, 4, {16'd0, 8'd100, 8'd105, 8'd155, 8'd205}, 8'd100);
        waitDrain();

        $display("[TB] request held during ramp");
        applyStimulus(1, 8'd255, 4, {16'd0, 8'd255, 8'd250, 8'd200, 8'd150}, 8'd255);
        applyStimulus(1, 8'd7, 5, {8'd0, 8'd7, 8'd55, 8'd105, 8'd155, 8'd205}, 8'd7);
        waitDrain();
        checkOutput("held request final cur_div", curDiv[1], 7);

        $display("[TB] ramp by 2 from 1 and back to bypass");
        applyStimulus(2, 8'd6, 3, {24'd0, 8'd6, 8'd5, 8'd3}, 8'd6);
        waitDrain();
        checkOutput("ramp up final clk_div", clkDiv[2], 6);
        applyStimulus(2, 8'd0, 3, {24'd0, 8'd1, 8'd2, 8'd4}, 8'd1);
        waitDrain();
        checkOutput("ramp down final clk_div", clkDiv[2], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
